// File: rtl/gray_pkg.sv
// Shared types for the Gray-code tracker: FSM states, step classes and
// error-counter sizing.
package gray_pkg;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        HOLD,
        UP,
        DOWN,
        ILLEGAL
    } delta_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_tracker_if.sv
// Sample stream in, decoded position/status out.
// The source side is master, the tracker is slave.
interface gray_tracker_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
);
    logic                           in_valid;
    logic [WIDTH-1:0]               gray_in;
    logic                           clr;
    logic [WIDTH-1:0]               bin_out;
    logic [POS_W-1:0]               pos;
    logic                           step_valid;
    logic                           dir;
    logic                           err;
    logic                           fault;
    logic [gray_pkg::ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, gray_in, clr,
        input  bin_out, pos, step_valid, dir, err, fault, err_cnt
    );

    modport slave (
        input  in_valid, gray_in, clr,
        output bin_out, pos, step_valid, dir, err, fault, err_cnt
    );
endinterface

// File: rtl/gray_to_bin.sv
// Reflected-binary Gray to binary decoder, purely combinational.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/gray_tracker.sv
// Gray-stream tracker: decode, classify hold/+1/-1/illegal, accumulate position.
// Define GRAY_TRACKER_ERR_CNT_EN to build the saturating err_cnt register.
module gray_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
) (
    input logic          clk,
    input logic          rst,
    gray_tracker_if.slave bus
);
    localparam logic [WIDTH-1:0] D_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] D_MONE = '1;
    localparam logic [POS_W-1:0] P_ONE  = POS_W'(1);

    state_t           state;
    delta_t           cls;
    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] bin_q;
    logic [POS_W-1:0] pos_q;
    logic             step_q;
    logic             dir_q;
    logic             err_q;
    logic             fault_q;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (bus.gray_in),
        .bin  (b_new)
    );

    // Modulo-2^WIDTH difference makes the code wrap a legal single step
    assign delta = b_new - ref_q;

    always_comb begin
        cls = ILLEGAL;
        unique case (1'b1)
            (delta == '0):     cls = HOLD;
            (delta == D_ONE):  cls = UP;
            (delta == D_MONE): cls = DOWN;
            default:           cls = ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            ref_q   <= '0;
            bin_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.clr) begin
                state   <= INIT;
                pos_q   <= '0;
                fault_q <= 1'b0;
            end else if (bus.in_valid) begin
                ref_q <= b_new;
                bin_q <= b_new;
                unique case (state)
                    INIT: state <= TRACK;
                    TRACK: begin
                        unique case (cls)
                            HOLD: ;
                            UP: begin
                                pos_q  <= pos_q + P_ONE;
                                step_q <= 1'b1;
                                dir_q  <= 1'b1;
                            end
                            DOWN: begin
                                pos_q  <= pos_q - P_ONE;
                                step_q <= 1'b1;
                                dir_q  <= 1'b0;
                            end
                            ILLEGAL: begin
                                err_q   <= 1'b1;
                                fault_q <= 1'b1;
                                state   <= FAULT;
                            end
                        endcase
                    end
                    FAULT: err_q <= (cls == ILLEGAL);
                    default: state <= INIT;
                endcase
            end
        end
    end

`ifdef GRAY_TRACKER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q;
    logic                 cnt_inc;

    assign cnt_inc = bus.in_valid && !bus.clr && (state != INIT)
                     && (cls == ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_inc && cnt_q != ERR_CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.err_cnt = cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.bin_out    = bin_q;
    assign bus.pos        = pos_q;
    assign bus.step_valid = step_q;
    assign bus.dir        = dir_q;
    assign bus.err        = err_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Self-checking bench for gray_tracker: vector table, reference model
// with scoreboard queue, and directed multi-cycle sequences.
module tb_gray_tracker;

    typedef struct packed {
        logic [3:0]  bin;
        logic [15:0] pos;
        logic        step;
        logic        dir;
        logic        err;
        logic        fault;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic       v;
        logic [3:0] g;
        logic       c;
        exp_t       e;
    } vec_t;

`ifdef GRAY_TRACKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_tracker_if #(.WIDTH(4), .POS_W(16)) bus ();
    gray_tracker_if #(.WIDTH(4), .POS_W(4))  wbus ();

    gray_tracker #(.WIDTH(4), .POS_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gray_tracker #(.WIDTH(4), .POS_W(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    int   tests = 0;
    int   fails = 0;
    int   n_step = 0;
    int   n_err = 0;
    exp_t q[$];
    vec_t vecs[13];

    int   m_state, m_ref, m_bin, m_pos, m_cnt;
    bit   m_dir;

    function automatic exp_t mk(int b, int p, bit s, bit d, bit e, bit f, int c);
        exp_t r;
        r.bin   = 4'(b);
        r.pos   = 16'(p);
        r.step  = s;
        r.dir   = d;
        r.err   = e;
        r.fault = f;
        r.cnt   = 8'(c);
        return r;
    endfunction

    function automatic int g2b(int g);
        for (int b = 0; b < 16; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [3:0] b2g(int b);
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic compare(input string name);
        exp_t e, a;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty got 1 want 0", name);
            return;
        end
        e = q.pop_front();
        if (!CNT_EN) e.cnt = 8'd0;
        a = '{bus.bin_out, bus.pos, bus.step_valid, bus.dir,
              bus.err, bus.fault, bus.err_cnt};
        if (bus.step_valid === 1'b1) n_step++;
        if (bus.err === 1'b1) n_err++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic apply(input logic v, input logic [3:0] g, input logic c,
                         input exp_t e, input string name);
        @(negedge clk);
        bus.in_valid = v;
        bus.gray_in  = g;
        bus.clr      = c;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        compare(name);
    endtask

    task automatic model_reset();
        m_state = 0; m_ref = 0; m_bin = 0;
        m_pos = 0; m_dir = 1'b1; m_cnt = 0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        compare(name);
        check({name, "_w"}, {28'd0, wbus.pos}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_apply(input bit v, input int g, input bit c,
                               input string name);
        int   b, d;
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0, 0);
        if (c) begin
            m_state = 0;
            m_pos = 0;
        end else if (v) begin
            b = g2b(g);
            d = (b - m_ref + 16) % 16;
            if (m_state == 1) begin
                if (d == 1) begin
                    m_pos++; m_dir = 1'b1; e.step = 1'b1;
                end else if (d == 15) begin
                    m_pos--; m_dir = 1'b0; e.step = 1'b1;
                end else if (d != 0) begin
                    e.err = 1'b1; m_state = 2;
                end
            end else if (m_state == 2) begin
                e.err = (d != 0 && d != 1 && d != 15);
            end else begin
                m_state = 1;
            end
            if (e.err && m_cnt < 255) m_cnt++;
            m_ref = b;
            m_bin = b;
        end
        e.bin   = 4'(m_bin);
        e.pos   = 16'(m_pos);
        e.dir   = m_dir;
        e.fault = (m_state == 2);
        e.cnt   = 8'(m_cnt);
        apply(v, 4'(g), c, e, name);
    endtask

    initial begin
        int s0, e0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.gray_in = 4'h0; bus.clr = 1'b0;
        wbus.in_valid = 1'b0; wbus.gray_in = 4'h0; wbus.clr = 1'b0;

        vecs[0]  = '{1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 1, 0, 0, 0)};
        vecs[1]  = '{1'b1, 4'b0001, 1'b0, mk(1, 1, 1, 1, 0, 0, 0)};
        vecs[2]  = '{1'b1, 4'b0001, 1'b0, mk(1, 1, 0, 1, 0, 0, 0)};
        vecs[3]  = '{1'b1, 4'b0000, 1'b0, mk(0, 0, 1, 0, 0, 0, 0)};
        vecs[4]  = '{1'b0, 4'b0100, 1'b0, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{1'b1, 4'b0100, 1'b0, mk(7, 0, 0, 0, 1, 1, 1)};
        vecs[6]  = '{1'b1, 4'b0101, 1'b0, mk(6, 0, 0, 0, 0, 1, 1)};
        vecs[7]  = '{1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 0, 1, 1, 2)};
        vecs[8]  = '{1'b1, 4'b0001, 1'b1, mk(0, 0, 0, 0, 0, 0, 2)};
        vecs[9]  = '{1'b1, 4'b1000, 1'b0, mk(15, 0, 0, 0, 0, 0, 2)};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, mk(0, 1, 1, 1, 0, 0, 2)};
        vecs[11] = '{1'b1, 4'b1000, 1'b0, mk(15, 0, 1, 0, 0, 0, 2)};
        vecs[12] = '{1'b1, 4'b1001, 1'b0, mk(14, 16'hFFFF, 1, 0, 0, 0, 2)};

        do_reset("reset_state");
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].v, vecs[i].g, vecs[i].c, vecs[i].e,
                  $sformatf("vec%0d", i));
        end

        do_reset("reset_sweep");
        s0 = n_step; e0 = n_err;
        for (int i = 0; i <= 16; i++) model_apply(1, b2g(i % 16), 0, "up_sweep");
        check("up_pos", {16'd0, bus.pos}, 32'd16);
        check("up_steps", n_step - s0, 16);
        check("up_errs", n_err - e0, 0);

        do_reset("reset_rev");
        model_apply(1, b2g(0), 0, "rev_sweep");
        for (int i = 15; i >= 1; i--) model_apply(1, b2g(i), 0, "rev_sweep");
        check("rev_pos", {16'd0, bus.pos}, 32'hFFF1);
        check("rev_dir", {31'd0, bus.dir}, 32'd0);

        do_reset("reset_hold");
        s0 = n_step;
        for (int i = 0; i < 3; i++) model_apply(1, 4'b0110, 0, "hold");
        check("hold_steps", n_step - s0, 0);

        do_reset("reset_mid");
        for (int i = 0; i <= 5; i++) model_apply(1, b2g(i), 0, "mid_up");
        check("mid_pos5", {16'd0, bus.pos}, 32'd5);
        do_reset("reset_mid_rst");
        model_apply(1, b2g(9), 0, "post_rst_init");

        do_reset("reset_sat");
        model_apply(1, 4'b0000, 0, "sat_init");
        for (int i = 0; i < 300; i++) begin
            model_apply(1, (i % 2 == 0) ? 4'b0100 : 4'b0000, 0, "sat");
        end
        check("sat_cnt", {24'd0, bus.err_cnt}, CNT_EN ? 32'd255 : 32'd0);

        do_reset("reset_wrap");
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            wbus.in_valid = 1'b1;
            wbus.gray_in  = b2g(i);
            @(posedge clk);
            #1;
            wbus.in_valid = 1'b0;
            if (i == 7) check("wrap_pos7", {28'd0, wbus.pos}, 32'd7);
        end
        check("wrap_pos", {28'd0, wbus.pos}, 32'h8);
        check("wrap_err", {31'd0, wbus.fault}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
